// File: rtl/fetch_ctrl_pkg.sv
// Shared LC-3b fetch types: fetch FSM state encoding and PC mux select values.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  localparam logic PCMUX_PLUS2  = 1'b0;
  localparam logic PCMUX_BRANCH = 1'b1;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle: memory handshake, decode backpressure, redirect and PC/IR controls.
interface fetch_ctrl_if;

  logic        imem_resp;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_read;
  logic        loadpc;
  logic        pcmux_sel;
  logic [15:0] branch_out;
  logic        ir_load;
  logic        if_valid;

  modport master (
    input  imem_resp, stall, branch_taken, branch_target,
    output imem_read, loadpc, pcmux_sel, branch_out, ir_load, if_valid
  );

  modport slave (
    output imem_resp, stall, branch_taken, branch_target,
    input  imem_read, loadpc, pcmux_sel, branch_out, ir_load, if_valid
  );

endinterface

// File: rtl/fetch_ctrl_perf_counter.sv
// Width-parameterised free-running event counter; wraps at all-ones, async active-low clear.
module perf_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (en)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences imem reads, IF/ID loading, stalls and branch redirects.
// Optional bubble counter output perf_bubbles is built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_ctrl_if.master  bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]   perf_bubbles
`endif
);

  fetch_state_t state, state_next;
  logic [15:0]  branch_q;
  logic         capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      branch_q <= 16'h0000;
    else if (capture)
      branch_q <= bus.branch_target;
  end

  assign bus.branch_out = branch_q;

  // Redirects are captured in every active state; the PC only moves once no read is in flight.
  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    bus.imem_read = 1'b0;
    bus.loadpc    = 1'b0;
    bus.pcmux_sel = PCMUX_PLUS2;
    bus.ir_load   = 1'b0;
    bus.if_valid  = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        bus.imem_read = 1'b1;
        if (bus.branch_taken) begin
          capture = 1'b1;
          if (bus.imem_resp) begin
            bus.loadpc    = 1'b1;
            bus.pcmux_sel = PCMUX_BRANCH;
          end else begin
            state_next = KILL;
          end
        end else if (bus.imem_resp) begin
          bus.ir_load  = 1'b1;
          bus.if_valid = 1'b1;
          if (bus.stall)
            state_next = HOLD;
          else
            bus.loadpc = 1'b1;
        end
      end
      KILL: begin
        bus.imem_read = 1'b1;
        capture       = bus.branch_taken;
        if (bus.imem_resp) begin
          bus.loadpc    = 1'b1;
          bus.pcmux_sel = PCMUX_BRANCH;
          state_next    = REQ;
        end
      end
      HOLD: begin
        bus.if_valid = 1'b1;
        if (bus.branch_taken) begin
          capture       = 1'b1;
          bus.loadpc    = 1'b1;
          bus.pcmux_sel = PCMUX_BRANCH;
          bus.if_valid  = 1'b0;
          state_next    = REQ;
        end else if (!bus.stall) begin
          bus.loadpc = 1'b1;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  logic bubble;

  assign bubble = (state != IDLE) && (!bus.if_valid || bus.stall);

  perf_counter #(.WIDTH(16)) u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble),
    .count (perf_bubbles)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a rule model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] perf_bubbles;
`endif

  fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_bubbles (perf_bubbles)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Reference model: "started" = reset has been left, "kill" = a redirect waits for the
  // outstanding read to drain, "hold" = an instruction is parked because decode stalled.
  bit          m_started, m_kill, m_hold;
  logic [15:0] m_target;
  logic [15:0] m_bubbles;
  logic        e_read, e_loadpc, e_sel, e_ir, e_valid;

  function automatic void model_reset();
    m_started = 1'b0;
    m_kill    = 1'b0;
    m_hold    = 1'b0;
    m_target  = 16'h0000;
    m_bubbles = 16'h0000;
  endfunction

  function automatic void predict();
    e_read = 1'b0; e_loadpc = 1'b0; e_sel = 1'b0; e_ir = 1'b0; e_valid = 1'b0;
    if (!m_started) begin
      // first cycle out of reset: nothing happens
    end else if (m_hold) begin
      e_valid = !bus.branch_taken;
      e_loadpc = bus.branch_taken || !bus.stall;
      e_sel = bus.branch_taken;
    end else if (m_kill) begin
      e_read = 1'b1;
      e_loadpc = bus.imem_resp;
      e_sel = bus.imem_resp;
    end else begin
      e_read = 1'b1;
      if (bus.branch_taken) begin
        e_loadpc = bus.imem_resp;
        e_sel = bus.imem_resp;
      end else begin
        e_ir = bus.imem_resp;
        e_valid = bus.imem_resp;
        e_loadpc = bus.imem_resp && !bus.stall;
      end
    end
  endfunction

  function automatic void advance();
    if (m_started && (!e_valid || bus.stall)) m_bubbles = m_bubbles + 16'd1;
    if (m_started && bus.branch_taken) m_target = bus.branch_target;
    if (!m_started) m_started = 1'b1;
    else if (m_hold) m_hold = !(bus.branch_taken || !bus.stall);
    else if (m_kill) m_kill = !bus.imem_resp;
    else if (bus.branch_taken) m_kill = !bus.imem_resp;
    else m_hold = bus.imem_resp && bus.stall;
  endfunction

  // Called at posedge+1: drive inputs, let them settle, compute expectations.
  task automatic set_inputs(input bit r, input bit s, input bit b, input logic [15:0] t);
    bus.imem_resp = r; bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    #2;
    predict();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    model_reset();
    rst_n = 1'b0;
    bus.imem_resp = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 16'hABCD;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.imem_read !== 1'b0) $display("[TB] FAIL reset_imem_read: got %b expected 0", bus.imem_read); else passed++;
    checks++; if (bus.loadpc !== 1'b0) $display("[TB] FAIL reset_loadpc: got %b expected 0", bus.loadpc); else passed++;
    checks++; if (bus.ir_load !== 1'b0 || bus.if_valid !== 1'b0) $display("[TB] FAIL reset_ir: got ir_load=%b if_valid=%b expected 0/0", bus.ir_load, bus.if_valid); else passed++;
    checks++; if (bus.branch_out !== 16'h0000) $display("[TB] FAIL reset_branch_out: got %h expected 0000", bus.branch_out); else passed++;
`ifdef FETCH_CTRL_PERF_EN
    checks++; if (perf_bubbles !== 16'h0000) $display("[TB] FAIL reset_perf: got %h expected 0000", perf_bubbles); else passed++;
`endif
    rst_n = 1'b1;
    set_inputs(1'b1, 1'b0, 1'b0, 16'h0000);
    checks++; if (bus.imem_read !== 1'b0) $display("[TB] FAIL idle_imem_read: got %b expected 0", bus.imem_read); else passed++;
    clock_edge();
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (bus.imem_read !== 1'b1) $display("[TB] FAIL first_imem_read: got %b expected 1", bus.imem_read); else passed++;
    clock_edge();
  endtask

  task automatic test_stream();
    $display("[TB] test_stream");
    for (int i = 0; i < 8; i++) begin
      set_inputs(1'b1, 1'b0, 1'b0, 16'($urandom));
      checks++; if (bus.loadpc !== e_loadpc || bus.ir_load !== e_ir || bus.pcmux_sel !== e_sel || bus.if_valid !== e_valid)
        $display("[TB] FAIL stream[%0d]: got loadpc=%b ir_load=%b sel=%b valid=%b expected %b %b %b %b",
                 i, bus.loadpc, bus.ir_load, bus.pcmux_sel, bus.if_valid, e_loadpc, e_ir, e_sel, e_valid);
      else passed++;
      clock_edge();
    end
  endtask

  task automatic test_stall_hold();
    $display("[TB] test_stall_hold");
    set_inputs(1'b1, 1'b1, 1'b0, 16'h0000);
    checks++; if (bus.ir_load !== e_ir || bus.loadpc !== e_loadpc) $display("[TB] FAIL stall_enter: got ir_load=%b loadpc=%b expected %b %b", bus.ir_load, bus.loadpc, e_ir, e_loadpc); else passed++;
    clock_edge();
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'(i[0]), 1'b1, 1'b0, 16'h0000);
      checks++; if (bus.imem_read !== e_read || bus.if_valid !== e_valid || bus.loadpc !== e_loadpc)
        $display("[TB] FAIL hold[%0d]: got read=%b valid=%b loadpc=%b expected %b %b %b", i, bus.imem_read, bus.if_valid, bus.loadpc, e_read, e_valid, e_loadpc);
      else passed++;
      clock_edge();
    end
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (bus.loadpc !== e_loadpc || bus.pcmux_sel !== e_sel) $display("[TB] FAIL hold_release: got loadpc=%b sel=%b expected %b %b", bus.loadpc, bus.pcmux_sel, e_loadpc, e_sel); else passed++;
    clock_edge();
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (bus.imem_read !== e_read) $display("[TB] FAIL hold_back_to_req: got read=%b expected %b", bus.imem_read, e_read); else passed++;
    clock_edge();
  endtask

  task automatic test_branch_kill();
    $display("[TB] test_branch_kill");
    set_inputs(1'b0, 1'b0, 1'b1, 16'h3000);
    checks++; if (bus.loadpc !== e_loadpc || bus.if_valid !== e_valid || bus.imem_read !== e_read)
      $display("[TB] FAIL branch_no_resp: got loadpc=%b valid=%b read=%b expected %b %b %b", bus.loadpc, bus.if_valid, bus.imem_read, e_loadpc, e_valid, e_read);
    else passed++;
    clock_edge();
    checks++; if (bus.branch_out !== 16'h3000) $display("[TB] FAIL kill_target: got %h expected 3000", bus.branch_out); else passed++;
    set_inputs(1'b0, 1'b1, 1'b0, 16'hFFFF);
    checks++; if (bus.loadpc !== e_loadpc || bus.imem_read !== e_read) $display("[TB] FAIL kill_wait: got loadpc=%b read=%b expected %b %b", bus.loadpc, bus.imem_read, e_loadpc, e_read); else passed++;
    clock_edge();
    set_inputs(1'b1, 1'b0, 1'b0, 16'hFFFF);
    checks++; if (bus.loadpc !== e_loadpc || bus.pcmux_sel !== e_sel || bus.if_valid !== e_valid || bus.ir_load !== e_ir)
      $display("[TB] FAIL kill_resp: got loadpc=%b sel=%b valid=%b ir_load=%b expected %b %b %b %b", bus.loadpc, bus.pcmux_sel, bus.if_valid, bus.ir_load, e_loadpc, e_sel, e_valid, e_ir);
    else passed++;
    clock_edge();
    set_inputs(1'b1, 1'b0, 1'b1, 16'h0ABC);
    checks++; if (bus.loadpc !== e_loadpc || bus.pcmux_sel !== e_sel || bus.ir_load !== e_ir || bus.if_valid !== e_valid)
      $display("[TB] FAIL branch_with_resp: got loadpc=%b sel=%b ir_load=%b valid=%b expected %b %b %b %b", bus.loadpc, bus.pcmux_sel, bus.ir_load, bus.if_valid, e_loadpc, e_sel, e_ir, e_valid);
    else passed++;
    clock_edge();
    checks++; if (bus.branch_out !== 16'h0ABC) $display("[TB] FAIL branch_with_resp_target: got %h expected 0abc", bus.branch_out); else passed++;
  endtask

  task automatic test_kill_redirect();
    $display("[TB] test_kill_redirect");
    set_inputs(1'b0, 1'b0, 1'b1, 16'h1234);
    clock_edge();
    set_inputs(1'b1, 1'b0, 1'b1, 16'h4000);
    checks++; if (bus.loadpc !== e_loadpc || bus.pcmux_sel !== e_sel) $display("[TB] FAIL kill_redirect_load: got loadpc=%b sel=%b expected %b %b", bus.loadpc, bus.pcmux_sel, e_loadpc, e_sel); else passed++;
    clock_edge();
    checks++; if (bus.branch_out !== 16'h4000) $display("[TB] FAIL kill_redirect_target: got %h expected 4000", bus.branch_out); else passed++;
  endtask

  task automatic test_hold_branch();
    $display("[TB] test_hold_branch");
    set_inputs(1'b1, 1'b1, 1'b0, 16'h0000);
    clock_edge();
    set_inputs(1'b0, 1'b1, 1'b1, 16'h2222);
    checks++; if (bus.loadpc !== e_loadpc || bus.pcmux_sel !== e_sel || bus.if_valid !== e_valid || bus.imem_read !== e_read)
      $display("[TB] FAIL hold_branch: got loadpc=%b sel=%b valid=%b read=%b expected %b %b %b %b", bus.loadpc, bus.pcmux_sel, bus.if_valid, bus.imem_read, e_loadpc, e_sel, e_valid, e_read);
    else passed++;
    clock_edge();
    checks++; if (bus.branch_out !== 16'h2222) $display("[TB] FAIL hold_branch_target: got %h expected 2222", bus.branch_out); else passed++;
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (bus.imem_read !== e_read) $display("[TB] FAIL hold_branch_req: got read=%b expected %b", bus.imem_read, e_read); else passed++;
    clock_edge();
  endtask

  task automatic test_reset_in_kill();
    $display("[TB] test_reset_in_kill");
    set_inputs(1'b0, 1'b0, 1'b1, 16'h5A5A);
    clock_edge();
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++; if (bus.imem_read !== e_read || bus.if_valid !== e_valid) $display("[TB] FAIL pre_reset_kill: got read=%b valid=%b expected %b %b", bus.imem_read, bus.if_valid, e_read, e_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.imem_read, bus.loadpc, bus.pcmux_sel, bus.ir_load, bus.if_valid} !== 5'b00000)
      $display("[TB] FAIL async_reset_outputs: got %b expected 00000", {bus.imem_read, bus.loadpc, bus.pcmux_sel, bus.ir_load, bus.if_valid});
    else passed++;
    checks++; if (bus.branch_out !== 16'h0000) $display("[TB] FAIL async_reset_branch_out: got %h expected 0000", bus.branch_out); else passed++;
`ifdef FETCH_CTRL_PERF_EN
    checks++; if (perf_bubbles !== 16'h0000) $display("[TB] FAIL async_reset_perf: got %h expected 0000", perf_bubbles); else passed++;
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_inputs(1'b0, 1'b0, 1'b0, 16'h0000);
    clock_edge();
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    for (int i = 0; i < 400; i++) begin
      set_inputs(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), 16'($urandom));
      checks++; if ({bus.imem_read, bus.loadpc, bus.pcmux_sel, bus.ir_load, bus.if_valid} !== {e_read, e_loadpc, e_sel, e_ir, e_valid})
        $display("[TB] FAIL random_outputs[%0d]: got read/loadpc/sel/ir/valid=%b expected %b", i,
                 {bus.imem_read, bus.loadpc, bus.pcmux_sel, bus.ir_load, bus.if_valid}, {e_read, e_loadpc, e_sel, e_ir, e_valid});
      else passed++;
`ifdef FETCH_CTRL_PERF_EN
      checks++; if (perf_bubbles !== m_bubbles) $display("[TB] FAIL random_perf[%0d]: got %0d expected %0d", i, perf_bubbles, m_bubbles); else passed++;
`endif
      clock_edge();
      checks++; if (bus.branch_out !== m_target) $display("[TB] FAIL random_branch_out[%0d]: got %h expected %h", i, bus.branch_out, m_target); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_branch_kill();
    test_kill_redirect();
    test_hold_branch();
    test_reset_in_kill();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
